// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the halt encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer for an instruction (and its PC+4) that returned while the pipe was stalled.
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  logic  i_clear,
    input  word_t i_instr,
    input  word_t i_npc,
    output logic  o_valid,
    output word_t o_instr,
    output word_t o_npc
);

    logic  r_valid;
    word_t r_instr;
    word_t r_npc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_npc   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_npc   <= i_npc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_npc   = r_npc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM and IF/ID write muxing.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT    = 32'h0000_0000,
    parameter word_t HALT_INSTR = cpu_types_pkg::HALT_INSTR
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  redirect_valid,
    input  word_t redirect_addr,
    output logic  ifid_WEN,
    output logic  ifid_flush,
    output word_t ifid_instruction,
    output word_t ifid_next_address,
    output logic  halted
);

    word_t        r_pc;
    fetch_state_t r_state;

    word_t        w_pc_d;
    fetch_state_t w_state_d;
    word_t        w_pc_plus4;
    logic         w_skid_load;
    logic         w_skid_clear;
    logic         w_skid_valid;
    word_t        w_skid_instr;
    word_t        w_skid_npc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign imemaddr   = r_pc;

    fetch_skid_buf u_skid (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (imemload),
        .i_npc   (w_pc_plus4),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_npc   (w_skid_npc)
    );

    always_comb begin
        w_pc_d            = r_pc;
        w_state_d         = r_state;
        w_skid_load       = 1'b0;
        w_skid_clear      = 1'b0;
        imemREN           = (r_state == FETCH);
        ifid_WEN          = 1'b0;
        ifid_flush        = 1'b0;
        ifid_instruction  = '0;
        ifid_next_address = '0;
        halted            = (r_state == HALTED);

        if (redirect_valid) begin
            // Any same-cycle ihit or stall is dropped; the target is word-aligned.
            w_pc_d       = redirect_addr & ~32'h3;
            w_state_d    = FETCH;
            w_skid_clear = 1'b1;
            ifid_flush   = 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (ihit && stall) begin
                        w_skid_load = 1'b1;
                        w_pc_d      = w_pc_plus4;
                        w_state_d   = HOLD;
                    end else if (ihit) begin
                        ifid_WEN          = 1'b1;
                        ifid_instruction  = imemload;
                        ifid_next_address = w_pc_plus4;
                        if (imemload == HALT_INSTR) begin
                            w_state_d = HALTED;
                        end else begin
                            w_pc_d = w_pc_plus4;
                        end
                    end
                end
                HOLD: begin
                    if (!stall && w_skid_valid) begin
                        ifid_WEN          = 1'b1;
                        ifid_instruction  = w_skid_instr;
                        ifid_next_address = w_skid_npc;
                        w_skid_clear      = 1'b1;
                        w_state_d         = (w_skid_instr == HALT_INSTR) ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                end
                default: begin
                    w_state_d = FETCH;
                end
            endcase
        end

        // Held in reset: every output sits at its reset value regardless of inputs.
        if (RST) begin
            imemREN           = 1'b0;
            ifid_WEN          = 1'b0;
            ifid_flush        = 1'b0;
            ifid_instruction  = '0;
            ifid_next_address = '0;
            halted            = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc    <= PC_INIT;
            r_state <= FETCH;
        end else begin
            r_pc    <= w_pc_d;
            r_state <= w_state_d;
        end
    end

endmodule
